round_controller: RTL

//  Game-round sequencer for the countdown timer and guess-checking logic.

---
 rtl/round_if.sv | 40 ++++
 rtl/round_controller.sv | 105 ++++++++++
 2 files changed

// File: rtl/round_if.sv
// Handshake bundle between the guess/button front end, the countdown timer and round_controller.
// The pause signal is present only when ROUND_PAUSE_EN is defined.
interface round_if #(
    parameter int MAX_ATTEMPTS = 5
) ();
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    logic          start;
    logic          guess_valid;
    logic          guess_correct;
    logic          timer_expires;
`ifdef ROUND_PAUSE_EN
    logic          pause;
`endif
    logic          timer_enable;
    logic          timer_reset;
    logic          guess_ready;
    logic [AW-1:0] attempts_left;
    logic [2:0]    state;
    logic          game_won;
    logic          game_lost;

    modport master (
`ifdef ROUND_PAUSE_EN
        output pause,
`endif
        output start, guess_valid, guess_correct, timer_expires,
        input  timer_enable, timer_reset, guess_ready, attempts_left,
        input  state, game_won, game_lost
    );

    modport slave (
`ifdef ROUND_PAUSE_EN
        input  pause,
`endif
        input  start, guess_valid, guess_correct, timer_expires,
        output timer_enable, timer_reset, guess_ready, attempts_left,
        output state, game_won, game_lost
    );
endinterface

// File: rtl/round_controller.sv
// Game-round sequencer: arms the countdown, gates its enable, takes guesses with a wrong-guess
// lockout and decides WIN/LOSE. Optional pause support is compiled in with ROUND_PAUSE_EN.
module round_controller #(
    parameter int MAX_ATTEMPTS   = 5,
    parameter int PENALTY_CYCLES = 0
) (
    input  logic   clk,
    input  logic   resetb,
    round_if.slave bus
);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    localparam int PW = (PENALTY_CYCLES > 0) ? $clog2(PENALTY_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] attempts_q, attempts_d;
    logic [PW-1:0] penalty_q, penalty_d;
    logic          accept;
    logic          pause_req;

`ifdef ROUND_PAUSE_EN
    assign pause_req = bus.pause;
`else
    assign pause_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q    <= IDLE;
            attempts_q <= AW'(MAX_ATTEMPTS);
            penalty_q  <= '0;
        end else begin
            state_q    <= state_d;
            attempts_q <= attempts_d;
            penalty_q  <= penalty_d;
        end
    end

    // A guess is only taken while the Moore guess_ready decode is high.
    assign accept = (state_q == RUN) && (penalty_q == '0) && bus.guess_valid;

    always_comb begin
        state_d    = state_q;
        attempts_d = attempts_q;
        penalty_d  = penalty_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = ARM;
            end
            ARM: begin
                attempts_d = AW'(MAX_ATTEMPTS);
                penalty_d  = '0;
                state_d    = RUN;
            end
            RUN: begin
                if (bus.timer_expires) begin
                    state_d = LOSE;
                end else if (accept) begin
                    if (bus.guess_correct) begin
                        state_d = WIN;
                    end else if (attempts_q <= AW'(1)) begin
                        attempts_d = '0;
                        state_d    = LOSE;
                    end else begin
                        attempts_d = attempts_q - AW'(1);
                        penalty_d  = PW'(PENALTY_CYCLES);
                        state_d    = pause_req ? PAUSE : RUN;
                    end
                end else if (pause_req) begin
                    // Lockout countdown is frozen from the cycle the pause is taken.
                    state_d = PAUSE;
                end else if (penalty_q != '0) begin
                    penalty_d = penalty_q - PW'(1);
                end
            end
`ifdef ROUND_PAUSE_EN
            PAUSE: begin
                if (bus.timer_expires)  state_d = LOSE;
                else if (!pause_req)    state_d = RUN;
            end
`endif
            WIN, LOSE: begin
                if (bus.start) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.timer_enable  = (state_q == RUN);
    assign bus.timer_reset   = (state_q == ARM);
    assign bus.guess_ready   = (state_q == RUN) && (penalty_q == '0);
    assign bus.attempts_left = attempts_q;
    assign bus.state         = state_q;
    assign bus.game_won      = (state_q == WIN);
    assign bus.game_lost     = (state_q == LOSE);

endmodule
